// File: rtl/fmap_tx_pkg.sv
// Shared types for the feature-map transmitter: the controller state encoding.
package fmap_tx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FULL   = 2'd1,
    STREAM = 2'd2,
    FLUSH  = 2'd3
  } fmap_tx_state_t;

endpackage

// File: rtl/fmap_tx_ram.sv
// Frame buffer: simple dual-port RAM, one write port, one registered read port.
module fmap_tx_ram #(
  parameter int WIDTH = 2048,
  parameter int DEPTH = 169,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // NOTE: the storage array has no reset so it maps onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read data holds between reads so the downstream sees a stable bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fmap_tx.sv
// Feature-map transmitter: buffers one frame via a load port, then streams it
// in raster order under ready flow control and pulses start after the last pixel.
module fmap_tx
  import fmap_tx_pkg::*;
#(
  parameter int  DATA_SIZE = 8,
  parameter int  CHANNELS  = 256,
  parameter int  IMG_DIM   = 13,
  localparam int NPIX      = IMG_DIM * IMG_DIM,
  localparam int AW        = $clog2(NPIX)
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_load_we,
  input  logic [AW-1:0]                       i_load_addr,
  input  logic [CHANNELS-1:0][DATA_SIZE-1:0]  i_load_data,
  input  logic                                i_load_done,
  output logic                                o_load_ready,
  input  logic                                i_next_ready,
  output logic [CHANNELS-1:0][DATA_SIZE-1:0]  o_next_data,
  output logic [CHANNELS-1:0]                 o_next_we,
  output logic                                o_next_start,
  output logic                                o_busy
);

  fmap_tx_state_t state;
  logic [AW-1:0]  rd_cnt;
  logic           rd_issued;
  logic           start_q;

  logic           rd_en;
  logic [AW-1:0]  rd_addr;
  logic           wr_en;

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = rd_cnt;
    wr_en   = 1'b0;
    if (state == FULL || state == STREAM) begin
      rd_en = i_next_ready;
    end
    if (state == FULL) begin
      rd_addr = '0;
    end
    // Compare one bit wider so the bound also works when NPIX is a power of two.
    if (state == IDLE && i_load_we && ({1'b0, i_load_addr} < (AW+1)'(NPIX))) begin
      wr_en = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_cnt    <= '0;
      rd_issued <= 1'b0;
      start_q   <= 1'b0;
    end else begin
      rd_issued <= rd_en;
      start_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_load_done) begin
            state <= FULL;
          end
        end
        FULL: begin
          if (i_next_ready) begin
            state  <= STREAM;
            rd_cnt <= AW'(1);
          end
        end
        STREAM: begin
          if (i_next_ready) begin
            if (rd_cnt == AW'(NPIX - 1)) begin
              state  <= FLUSH;
              rd_cnt <= '0;
            end else begin
              rd_cnt <= rd_cnt + AW'(1);
            end
          end
        end
        FLUSH: begin
          // Last pixel is on the bus this cycle; start follows with the return to IDLE.
          state   <= IDLE;
          start_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  fmap_tx_ram #(
    .WIDTH (DATA_SIZE * CHANNELS),
    .DEPTH (NPIX),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_en),
    .waddr (i_load_addr),
    .wdata (i_load_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (o_next_data)
  );

  assign o_next_we    = {CHANNELS{rd_issued}};
  assign o_next_start = start_q;
  assign o_busy       = (state != IDLE);
  assign o_load_ready = (state == IDLE);

endmodule

// File: tb/tb_fmap_tx.sv
// Self-checking bench for fmap_tx on a 3x3, 4-channel frame: table-driven
// first frame plus directed multi-cycle sequences.
module tb_fmap_tx;

  localparam int DATA_SIZE = 8;
  localparam int CHANNELS  = 4;
  localparam int IMG_DIM   = 3;
  localparam int NPIX      = IMG_DIM * IMG_DIM;
  localparam int AW        = $clog2(NPIX);
  localparam int W         = DATA_SIZE * CHANNELS;

  logic                               clk;
  logic                               rst_n;
  logic                               i_load_we;
  logic [AW-1:0]                      i_load_addr;
  logic [CHANNELS-1:0][DATA_SIZE-1:0] i_load_data;
  logic                               i_load_done;
  logic                               o_load_ready;
  logic                               i_next_ready;
  logic [CHANNELS-1:0][DATA_SIZE-1:0] o_next_data;
  logic [CHANNELS-1:0]                o_next_we;
  logic                               o_next_start;
  logic                               o_busy;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_mem [NPIX];

  fmap_tx #(
    .DATA_SIZE (DATA_SIZE),
    .CHANNELS  (CHANNELS),
    .IMG_DIM   (IMG_DIM)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_we    (i_load_we),
    .i_load_addr  (i_load_addr),
    .i_load_data  (i_load_data),
    .i_load_done  (i_load_done),
    .o_load_ready (o_load_ready),
    .i_next_ready (i_next_ready),
    .o_next_data  (o_next_data),
    .o_next_we    (o_next_we),
    .o_next_start (o_next_start),
    .o_busy       (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic ready;
    logic done;
    logic we;
    logic chk_data;
    int   pix;
    logic start;
    logic busy;
  } vec_t;

  vec_t tbl [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] ramp_pix(input int p);
    logic [W-1:0] v;
    v = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      v[c*DATA_SIZE +: DATA_SIZE] = DATA_SIZE'(p * CHANNELS + c);
    end
    return v;
  endfunction

  task automatic load_ramp();
    for (int p = 0; p < NPIX; p++) begin
      i_load_we   = 1'b1;
      i_load_addr = AW'(p);
      i_load_data = ramp_pix(p);
      exp_mem[p]  = ramp_pix(p);
      step();
    end
    i_load_we = 1'b0;
  endtask

  // Sends i_load_done, then collects one frame until the start pulse.
  // mode 0: ready high; mode 1: ready alternates 0,1; mode 2: ready high with 0xFF load writes while busy.
  task automatic stream_frame(input int mode, input string tag);
    int npix;
    int first_we;
    int starts;
    bit fin;
    npix     = 0;
    first_we = -1;
    starts   = 0;
    fin      = 1'b0;
    for (int i = 0; i < 60 && !fin; i++) begin
      i_load_done  = (i == 0);
      i_next_ready = (mode == 1) ? (i % 2 == 1) : 1'b1;
      if (mode == 2 && i >= 1) begin
        i_load_we   = 1'b1;
        i_load_addr = AW'(i % NPIX);
        i_load_data = '1;
      end
      step();
      i_load_done = 1'b0;
      if (mode != 2) i_load_we = 1'b0;
      if (o_next_we !== '0) begin
        check({tag, " we_bits"}, 64'(o_next_we), 64'hF);
        check({tag, " we_after_ready"}, 64'(i_next_ready), 64'd1);
        if (npix < NPIX) check({tag, " data"}, 64'(o_next_data), 64'(exp_mem[npix]));
        else             check({tag, " extra_pixel"}, 64'(npix), 64'(NPIX - 1));
        if (first_we < 0) first_we = i;
        npix++;
      end
      if (o_next_start === 1'b1) begin
        starts++;
        check({tag, " start_no_we"}, 64'(o_next_we), 64'd0);
        check({tag, " pixels_at_start"}, 64'(npix), 64'(NPIX));
        check({tag, " load_ready_at_start"}, 64'(o_load_ready), 64'd1);
        check({tag, " busy_at_start"}, 64'(o_busy), 64'd0);
        fin = 1'b1;
      end else if (mode == 2) begin
        check({tag, " load_ready_low"}, 64'(o_load_ready), 64'd0);
      end
    end
    check({tag, " start_count"}, 64'(starts), 64'd1);
    if (mode != 1) check({tag, " first_we_latency"}, 64'(first_we), 64'd1);
    i_load_we    = 1'b0;
    i_next_ready = 1'b0;
  endtask

  initial begin
    int cnt;
    rst_n        = 1'b0;
    i_load_we    = 1'b0;
    i_load_addr  = '0;
    i_load_data  = '0;
    i_load_done  = 1'b0;
    i_next_ready = 1'b0;

    // Reset state
    #3;
    check("rst we", 64'(o_next_we), 64'd0);
    check("rst start", 64'(o_next_start), 64'd0);
    check("rst data", 64'(o_next_data), 64'd0);
    check("rst busy", 64'(o_busy), 64'd0);
    check("rst load_ready", 64'(o_load_ready), 64'd1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Ramp frame, ready high, table-driven
    load_ramp();
    tbl[0] = '{ready: 1'b0, done: 1'b1, we: 1'b0, chk_data: 1'b0, pix: 0, start: 1'b0, busy: 1'b1};
    for (int p = 0; p < NPIX; p++) begin
      tbl[p+1] = '{ready: 1'b1, done: 1'b0, we: 1'b1, chk_data: 1'b1, pix: p, start: 1'b0, busy: 1'b1};
    end
    tbl[10] = '{ready: 1'b1, done: 1'b0, we: 1'b0, chk_data: 1'b1, pix: NPIX-1, start: 1'b1, busy: 1'b0};
    tbl[11] = '{ready: 1'b0, done: 1'b0, we: 1'b0, chk_data: 1'b1, pix: NPIX-1, start: 1'b0, busy: 1'b0};
    for (int r = 0; r < 12; r++) begin
      i_next_ready = tbl[r].ready;
      i_load_done  = tbl[r].done;
      step();
      check($sformatf("tbl%0d we", r), 64'(o_next_we), tbl[r].we ? 64'hF : 64'h0);
      if (tbl[r].chk_data)
        check($sformatf("tbl%0d data", r), 64'(o_next_data), 64'(exp_mem[tbl[r].pix]));
      check($sformatf("tbl%0d start", r), 64'(o_next_start), 64'(tbl[r].start));
      check($sformatf("tbl%0d busy", r), 64'(o_busy), 64'(tbl[r].busy));
      check($sformatf("tbl%0d load_ready", r), 64'(o_load_ready), 64'(!tbl[r].busy));
    end
    i_load_done  = 1'b0;
    i_next_ready = 1'b0;

    // Ready toggling
    stream_frame(1, "toggle");
    step();

    // Loads outside IDLE, then a back-to-back resend without reloading
    stream_frame(2, "ff_during_stream");
    stream_frame(0, "back_to_back");

    // Reset mid-operation after 4 pixels
    step();
    i_load_done = 1'b1;
    step();
    i_load_done  = 1'b0;
    i_next_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 4; i++) begin
      step();
      if (o_next_we !== '0) cnt++;
    end
    check("midrst we_seen", 64'(cnt), 64'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst we", 64'(o_next_we), 64'd0);
    check("midrst start", 64'(o_next_start), 64'd0);
    check("midrst data", 64'(o_next_data), 64'd0);
    check("midrst busy", 64'(o_busy), 64'd0);
    check("midrst load_ready", 64'(o_load_ready), 64'd1);
    i_next_ready = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("postrst start", 64'(o_next_start), 64'd0);
    check("postrst busy", 64'(o_busy), 64'd0);
    stream_frame(0, "after_reset");

    // Boundary write to NPIX is dropped; a write on the done cycle still commits
    step();
    i_load_we   = 1'b1;
    i_load_addr = AW'(NPIX);
    i_load_data = '1;
    step();
    i_load_addr = AW'(4);
    i_load_data = {CHANNELS{8'hAA}};
    exp_mem[4]  = {CHANNELS{8'hAA}};
    stream_frame(0, "boundary");

    step();
    check("final start", 64'(o_next_start), 64'd0);
    check("final busy", 64'(o_busy), 64'd0);
    check("final we", 64'(o_next_we), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fmap_tx.md
# fmap_tx

Feature-map transmitter that drives a layer's input-buffer write interface (`*_ibuf_we` / `*_ibuf_wr_data` / `*_start`), as consumed by the pooling and CIM layers. It holds one complete IMG_DIM×IMG_DIM frame for all channels, filled through a random-access load port. It then streams the frame in raster order, one pixel per cycle across all channels, under downstream `ready` flow control. After the last pixel it pulses `start` so the receiving layer begins processing.

## Interface
- `DATA_SIZE`, 8, bits per pixel per channel.
- `CHANNELS`, 256, number of channels transmitted in parallel.
- `IMG_DIM`, 13, frame width and height.
- `NPIX` (localparam) = IMG_DIM*IMG_DIM.
- `AW` (localparam) = $clog2(NPIX).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `i_load_we`  in  1  load-port write strobe.
- `i_load_addr`  in  AW  pixel index, row*IMG_DIM+col.
- `i_load_data`  in  DATA_SIZE×[CHANNELS]  pixel value for every channel.
- `i_load_done`  in  1  frame-complete pulse from the loader.
- `o_load_ready`  out  1  high only in IDLE.
- `i_next_ready`  in  1  downstream can accept a pixel.
- `o_next_data`  out  DATA_SIZE×[CHANNELS]  pixel data to the downstream ibuf.
- `o_next_we`  out  CHANNELS  per-channel write strobe; all bits are driven identically.
- `o_next_start`  out  1  one-cycle frame-complete pulse.
- `o_busy`  out  1  high in FULL, STREAM, and FLUSH.

## Operation
- **States:** IDLE, FULL, STREAM, FLUSH.
- **IDLE**
  - Every `i_load_we` writes `i_load_data` at `i_load_addr`.
  - Addresses ≥ NPIX are dropped.
  - `i_load_done` moves to FULL. A write in the same cycle as `i_load_done` is still committed.
- **FULL**
  - Load writes are ignored.
  - If `i_next_ready`=1: issue a read of address 0, then go to STREAM with `rd_cnt`=1.
- **STREAM**
  - Each cycle with `i_next_ready`=1 issues a read of address `rd_cnt` and increments `rd_cnt`.
  - A read issued at address NPIX-1 moves to FLUSH.
  - `i_next_ready`=0 issues no read and holds `rd_cnt`.
- **FLUSH**
  - One cycle, in which the final pixel is presented on the output.
  - Then pulse `o_next_start` for one cycle and return to IDLE.
- **Output pairing:** every issued read produces exactly one cycle of `o_next_we`='1 with the matching `o_next_data`, one cycle later.
- **Inactive outputs:** `o_next_we`='0 whenever no read was issued in the previous cycle. `o_next_data` holds its last value.
- **Buffer contents:** the frame is not cleared between frames. Unwritten pixels transmit stale or undefined contents; this is the loader's responsibility.
- **Ignored inputs:** `i_load_done` outside IDLE is ignored. `i_load_we` outside IDLE is dropped with no side effect.

## Timing
- **Reset values:** state=IDLE, `rd_cnt`=0, `o_next_we`='0, `o_next_start`=0, `o_next_data`='0, `o_busy`=0, `o_load_ready`=1.
- **Mid-operation reset:** reset during any state returns immediately to these values. The frame RAM is not cleared.
- **Load-port latency:** a write at edge t is readable at edge t+1.
- **Start latency:** `i_load_done` at edge t puts the block in FULL at t+1. If `i_next_ready` is high, the first `o_next_we` appears at t+2.
- **Pixel latency:** read issued at edge t (`i_next_ready` sampled high), so `o_next_we`/`o_next_data` are valid in the cycle after edge t+1.
- **Throughput:** 1 pixel/cycle. With `i_next_ready` held high, NPIX consecutive `o_next_we` cycles.
- **Frame end:** `o_next_start` is asserted in the cycle immediately after the final `o_next_we` cycle, and never coincides with `o_next_we`.
- **Ready rule:** `i_next_ready` is sampled only at read issue. A read already in flight is always delivered, even if ready drops.
- **Minimum frame-to-frame gap:**
  - `o_next_start` is asserted in the same cycle the block re-enters IDLE.
  - `o_load_ready` is 1 in that cycle.
  - The next `i_load_done` can follow the next edge.
- **Counter width:** `rd_cnt` is AW bits and compares against NPIX-1 exactly, with no wrap.

## Structure
- **Package `fmap_tx_pkg`:** holds the state enum `fmap_tx_state_t` (IDLE, FULL, STREAM, FLUSH).
- **Sub-module `fmap_tx_ram`:**
  - Simple dual-port: one write port, one registered read port.
  - Width DATA_SIZE*CHANNELS, depth NPIX.
  - No reset on the storage array.
  - Its registered read-data output forms `o_next_data`.
- **Top level:** FSM, `rd_cnt`, a one-bit `rd_issued` register that drives `o_next_we`, and the start-pulse register.

## Test plan
- **Ramp frame, ready high.**
  - Stimulus: DATA_SIZE=8, CHANNELS=4, IMG_DIM=3. Load pixel p with channel c = p*4+c, then `i_load_done`.
  - Required: 9 consecutive `o_next_we`=4'hF cycles with data {0..3},{4..7},…,{32..35}, then `o_next_start` for exactly one cycle, then IDLE.
- **Ready toggling.**
  - Stimulus: same frame, `i_next_ready` alternating 1,0.
  - Required: exactly 9 we cycles, in order, with no duplicate or skipped pixel. Each we cycle follows a ready-high sample.
- **Loads outside IDLE.**
  - Stimulus: writes of 8'hFF to all addresses during STREAM, then a second frame is sent without reloading.
  - Required: both frames are identical to the ramp, and `o_load_ready`=0 throughout the first transfer.
- **Reset mid-operation.**
  - Stimulus: `rst_n` asserted after 4 we cycles.
  - Required: all outputs go to reset values asynchronously, with no `o_next_start`.
  - Required: a subsequent `i_load_done` streams the retained RAM contents from pixel 0.
- **Back-to-back frames.**
  - Stimulus: `i_load_done` asserted one edge after the first `o_next_start`.
  - Required: the second stream begins two cycles later, with exactly one start pulse per frame.
- **Boundary writes.**
  - Stimulus: write to address NPIX (9).
  - Required: ignored; pixel 0 is unchanged.
